// File: rtl/alu_pkg.sv
// Shared types, constants and word-format helpers for the ALU serial link.
package alu_pkg;

    localparam int unsigned WORD_BITS   = 10;
    localparam int unsigned FRAME_WORDS = 3;
    localparam int unsigned FRAME_BITS  = WORD_BITS * FRAME_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } tx_state_t;

    function automatic logic word_parity(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Word layout is {flag, byte, parity}; parity makes the whole word even.
    function automatic logic [WORD_BITS-1:0] build_word(input logic flag,
                                                        input logic [7:0] data_byte);
        return {flag, data_byte, word_parity({flag, data_byte})};
    endfunction

endpackage

// File: rtl/alu_frame_builder.sv
// Combinational packing of one ALU result into a 30-bit status/MSB/LSB frame.
module alu_frame_builder
    import alu_pkg::*;
#(
    parameter logic STATUS_FLAG = 1'b1
) (
    input  logic [7:0]            res_status,
    input  logic [15:0]           res_data,
    output logic [FRAME_BITS-1:0] frame
);

    assign frame = {build_word(STATUS_FLAG, res_status),
                    build_word(1'b0, res_data[15:8]),
                    build_word(1'b0, res_data[7:0])};

endmodule

// File: rtl/alu_serial_tx.sv
// Serialises accepted ALU results onto dout as 30-bit frames, MSB first, with a
// one-deep holding register and a configurable idle gap between frames.
module alu_serial_tx
    import alu_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter logic        STATUS_FLAG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [7:0]  res_status,
    input  logic [15:0] res_data,
    output logic        dout,
    output logic        dout_valid,
    output logic        tx_busy
);

    localparam logic [4:0] LastBit = 5'(FRAME_BITS - 1);
    localparam logic [3:0] LastGap = 4'(GAP_CYCLES - 1);

    tx_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [FRAME_BITS-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [3:0]            gap_cnt_q, gap_cnt_d;
    logic                  dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  res_ready_q;

    logic                  accept;
    logic                  load_in;
    logic                  load_hold;
    logic [FRAME_BITS-1:0] frame_in;
    logic [FRAME_BITS-1:0] frame_sel;

    alu_frame_builder #(
        .STATUS_FLAG(STATUS_FLAG)
    ) u_frame_builder (
        .res_status(res_status),
        .res_data  (res_data),
        .frame     (frame_in)
    );

    assign accept = res_valid && res_ready_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        load_in      = 1'b0;
        load_hold    = 1'b0;
        frame_sel    = frame_in;

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load_hold = 1'b1;
                end else if (accept) begin
                    load_in = 1'b1;
                end
            end

            SHIFT: begin
                if (accept) begin
                    hold_d      = frame_in;
                    hold_full_d = 1'b1;
                end
                if (bit_cnt_q == LastBit) begin
                    // With no gap a queued frame follows without dropping dout_valid.
                    if (GAP_CYCLES == 0 && hold_full_q) begin
                        load_hold = 1'b1;
                    end else begin
                        dout_d       = 1'b0;
                        dout_valid_d = 1'b0;
                        gap_cnt_d    = '0;
                        state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end else begin
                    dout_d    = shreg_q[FRAME_BITS-1];
                    shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end

            GAP: begin
                if (accept) begin
                    hold_d      = frame_in;
                    hold_full_d = 1'b1;
                end
                if (gap_cnt_q == LastGap) begin
                    // An accept on this edge lands in holding; IDLE launches it next.
                    if (hold_full_q) begin
                        load_hold = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        // The first bit goes out on the load edge, so the shifter keeps only the rest.
        if (load_in || load_hold) begin
            frame_sel    = load_hold ? hold_q : frame_in;
            shreg_d      = {frame_sel[FRAME_BITS-2:0], 1'b0};
            dout_d       = frame_sel[FRAME_BITS-1];
            dout_valid_d = 1'b1;
            bit_cnt_d    = '0;
            state_d      = SHIFT;
            if (load_hold) begin
                hold_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            res_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            res_ready_q  <= ~hold_full_d;
        end
    end

    assign res_ready  = res_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign tx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_serial_tx.sv
// Directed bench for alu_serial_tx: one instance with a 2-cycle gap, one with no gap.
module tb_alu_serial_tx;

    logic        clk;
    logic        rst;

    logic        res_valid, res_ready, dout, dout_valid, tx_busy;
    logic [7:0]  res_status;
    logic [15:0] res_data;

    logic        res_valid0, res_ready0, dout0, dout_valid0, tx_busy0;
    logic [7:0]  res_status0;
    logic [15:0] res_data0;

    int n_vec = 0;
    int n_err = 0;

    bit vq[$];
    bit dq[$];
    bit vq0[$];
    bit dq0[$];

    alu_serial_tx #(
        .GAP_CYCLES (2),
        .STATUS_FLAG(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_status(res_status),
        .res_data  (res_data),
        .dout      (dout),
        .dout_valid(dout_valid),
        .tx_busy   (tx_busy)
    );

    alu_serial_tx #(
        .GAP_CYCLES (0),
        .STATUS_FLAG(1'b1)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .res_valid (res_valid0),
        .res_ready (res_ready0),
        .res_status(res_status0),
        .res_data  (res_data0),
        .dout      (dout0),
        .dout_valid(dout_valid0),
        .tx_busy   (tx_busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        vq.push_back(dout_valid);
        dq.push_back(dout);
        vq0.push_back(dout_valid0);
        dq0.push_back(dout0);
    endtask

    task automatic clear_logs();
        vq.delete();
        dq.delete();
        vq0.delete();
        dq0.delete();
    endtask

    function automatic bit vget(input int sel, input int i);
        return (sel != 0) ? vq0[i] : vq[i];
    endfunction

    function automatic bit dget(input int sel, input int i);
        return (sel != 0) ? dq0[i] : dq[i];
    endfunction

    function automatic int log_size(input int sel);
        return (sel != 0) ? vq0.size() : vq.size();
    endfunction

    function automatic int count_valid(input int sel, input int from);
        int c = 0;
        for (int i = from; i < log_size(sel); i++) if (vget(sel, i)) c++;
        return c;
    endfunction

    // Deserialise the first frame at or after 'from'; ok is cleared on any hole.
    task automatic get_frame(input int sel, input int from, output logic [29:0] fr,
                             output int first, output bit ok);
        int n = log_size(sel);
        int i = from;
        while (i < n && !vget(sel, i)) i++;
        first = i;
        ok    = 1'b1;
        fr    = '0;
        for (int k = 0; k < 30; k++) begin
            if (i + k >= n) begin
                ok = 1'b0;
            end else begin
                if (!vget(sel, i + k)) ok = 1'b0;
                fr[29-k] = dget(sel, i + k);
            end
        end
    endtask

    function automatic bit odd_ones(input logic [9:0] w);
        int c = 0;
        for (int b = 0; b < 10; b++) if (w[b]) c++;
        return (c % 2) != 0;
    endfunction

    logic [29:0] fr;
    int          first, first_b;
    bit          ok;
    int          par_err;
    logic [7:0]  st;

    initial begin
        rst = 1'b1;
        res_valid = 1'b0; res_status = '0; res_data = '0;
        res_valid0 = 1'b0; res_status0 = '0; res_data0 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout_valid", 32'(dout_valid), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_ready", 32'(res_ready), 32'h0);
        chk("rst_busy", 32'(tx_busy), 32'h0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(res_ready), 32'h1);

        // 1: single frame, 1-cycle latency, exactly 30 valid cycles
        clear_logs();
        res_valid = 1'b1; res_status = 8'h00; res_data = 16'h1234;
        step();
        res_valid = 1'b0;
        repeat (40) step();
        get_frame(0, 0, fr, first, ok);
        chk("t1_latency", 32'(first), 32'd0);
        chk("t1_frame", 32'(fr), 32'({10'h201, 10'h024, 10'h069}));
        chk("t1_contiguous", 32'(ok), 32'h1);
        chk("t1_valid_count", 32'(count_valid(0, 0)), 32'd30);
        chk("t1_idle_busy", 32'(tx_busy), 32'h0);

        // 2: back-to-back A then B with a 2-cycle gap
        clear_logs();
        res_valid = 1'b1; res_status = 8'h80; res_data = 16'hFFFF;
        step();
        chk("t2_ready_before_b", 32'(res_ready), 32'h1);
        res_status = 8'h01; res_data = 16'h0000;
        step();
        chk("t2_ready_after_b", 32'(res_ready), 32'h0);
        res_valid = 1'b0;
        repeat (75) step();
        get_frame(0, 0, fr, first, ok);
        chk("t2_a_frame", 32'(fr), 32'({10'h300, 10'h1FE, 10'h1FE}));
        chk("t2_a_lsb_word", 32'(fr[9:0]), 32'h1FE);
        get_frame(0, first + 30, fr, first_b, ok);
        chk("t2_gap_len", 32'(first_b - 30), 32'd2);
        chk("t2_b_frame", 32'(fr), 32'({10'h202, 10'h000, 10'h000}));
        chk("t2_b_contiguous", 32'(ok), 32'h1);

        // 3: no gap, two queued frames give 60 continuous valid cycles
        clear_logs();
        res_valid0 = 1'b1; res_status0 = 8'hC3; res_data0 = 16'h5A0F;
        step();
        res_status0 = 8'h3C; res_data0 = 16'h0F5A;
        step();
        res_valid0 = 1'b0;
        repeat (70) step();
        get_frame(1, 0, fr, first, ok);
        chk("t3_x_start", 32'(first), 32'd0);
        chk("t3_x_frame", 32'(fr), 32'({10'h387, 10'h0B4, 10'h01E}));
        get_frame(1, 30, fr, first, ok);
        chk("t3_y_start", 32'(first), 32'd30);
        chk("t3_y_frame", 32'(fr), 32'({10'h279, 10'h01E, 10'h0B4}));
        chk("t3_y_contiguous", 32'(ok), 32'h1);
        chk("t3_valid_count", 32'(count_valid(1, 0)), 32'd60);

        // 4: asynchronous reset in the middle of a frame
        clear_logs();
        res_valid = 1'b1; res_status = 8'h11; res_data = 16'h2222;
        step();
        res_valid = 1'b0;
        repeat (13) step();
        chk("t4_mid_frame", 32'(dout_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("t4_async_valid", 32'(dout_valid), 32'h0);
        chk("t4_async_dout", 32'(dout), 32'h0);
        chk("t4_async_ready", 32'(res_ready), 32'h0);
        chk("t4_async_busy", 32'(tx_busy), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        clear_logs();
        step();
        chk("t4_ready_after", 32'(res_ready), 32'h1);
        repeat (40) step();
        chk("t4_no_residue", 32'(count_valid(0, 0)), 32'd0);
        clear_logs();
        res_valid = 1'b1; res_status = 8'h55; res_data = 16'hA5A5;
        step();
        res_valid = 1'b0;
        repeat (35) step();
        get_frame(0, 0, fr, first, ok);
        chk("t4_new_start", 32'(first), 32'd0);
        chk("t4_new_frame", 32'(fr), 32'({10'h2AB, 10'h14A, 10'h14A}));

        // 5: parity sweep over random status bytes
        par_err = 0;
        for (int it = 0; it < 256; it++) begin
            clear_logs();
            st = 8'($urandom_range(255));
            res_valid = 1'b1; res_status = st; res_data = 16'($urandom_range(65535));
            step();
            res_valid = 1'b0;
            repeat (33) step();
            get_frame(0, 0, fr, first, ok);
            if (!ok || odd_ones(fr[29:20]) || odd_ones(fr[19:10]) || odd_ones(fr[9:0]) ||
                !fr[29] || fr[19] || fr[9]) par_err++;
            chk("t5_status", 32'(fr[28:21]), 32'(st));
        end
        chk("t5_parity_errors", 32'(par_err), 32'd0);

        // 6: res_valid pulsed while holding is full must be ignored
        clear_logs();
        res_valid = 1'b1; res_status = 8'hA1; res_data = 16'hB2C3;
        step();
        res_status = 8'h0D; res_data = 16'hE0F0;
        step();
        res_valid = 1'b0;
        repeat (3) step();
        chk("t6_ready_full", 32'(res_ready), 32'h0);
        res_valid = 1'b1; res_status = 8'hEE; res_data = 16'hEEEE;
        step();
        res_valid = 1'b0;
        repeat (80) step();
        get_frame(0, 0, fr, first, ok);
        chk("t6_p_frame", 32'(fr), 32'({10'h342, 10'h164, 10'h186}));
        get_frame(0, first + 30, fr, first_b, ok);
        chk("t6_q_start", 32'(first_b), 32'd32);
        chk("t6_q_frame", 32'(fr), 32'({10'h21A, 10'h1C1, 10'h1E0}));
        chk("t6_valid_count", 32'(count_valid(0, 0)), 32'd60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
